// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder with the SPI master's register map and streaming flags.
// Optional end-of-packet compare register enabled by defining SPI_SLAVE_EOP_EN.
module spi_slave_responder #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata,
  output logic        endofpacket
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATABITS - 1);

  // ---------------- register port strobes ----------------
  logic        rd_req, wr_req, rd_q, wr_q, rd_stb, wr_stb;
  logic [2:0]  acc_addr;
  logic [15:0] wdata_q;
  logic        rx_rd, tx_wr, st_wr, ctl_wr;
  logic        unused_wdata;

  assign rd_req = spi_select & ~read_n;
  assign wr_req = spi_select & ~write_n;

  // One strobe per contiguous request; address/data latched with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_stb   <= 1'b0;
      wr_stb   <= 1'b0;
      acc_addr <= '0;
      wdata_q  <= '0;
    end else begin
      rd_q   <= rd_req;
      wr_q   <= wr_req;
      rd_stb <= rd_req & ~rd_q;
      wr_stb <= wr_req & ~wr_q;
      if ((rd_req & ~rd_q) | (wr_req & ~wr_q)) begin
        acc_addr <= mem_addr;
        wdata_q  <= data_from_cpu;
      end
    end
  end

  assign rx_rd  = rd_stb & (acc_addr == 3'd0);
  assign tx_wr  = wr_stb & (acc_addr == 3'd1);
  assign st_wr  = wr_stb & (acc_addr == 3'd2);
  assign ctl_wr = wr_stb & (acc_addr == 3'd3);
  assign unused_wdata = ^wdata_q;

  // ---------------- input synchronisers ----------------
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_s, ss_s, mosi_s, sclk_d, ss_d;
  logic sclk_rise, sclk_fall, ss_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ss_d & ~ss_s;

  // ---------------- serial FSM ----------------
  state_t              state, state_nx;
  logic [DATABITS-1:0] shift_reg, shifted, tx_hold, rx_hold;
  logic [2:0]          bitcnt;
  logic                reload, tx_primed;
  logic                start, abort, shift_en, reload_now, byte_done, load_tx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    abort      = 1'b0;
    shift_en   = 1'b0;
    reload_now = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nx = ACTIVE;
          start    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_s) begin
          state_nx = IDLE;
          abort    = 1'b1;
        end else begin
          shift_en   = sclk_rise;
          reload_now = sclk_fall & reload;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign shifted   = {shift_reg[DATABITS-2:0], mosi_s};
  assign byte_done = shift_en & (bitcnt == LAST_BIT);
  assign load_tx   = start | reload_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      bitcnt    <= '0;
      reload    <= 1'b0;
      rx_hold   <= '0;
    end else begin
      if (load_tx)       shift_reg <= tx_primed ? tx_hold : '0;
      else if (shift_en) shift_reg <= shifted;

      if (start | abort)  bitcnt <= '0;
      else if (shift_en)  bitcnt <= byte_done ? 3'd0 : bitcnt + 3'd1;

      if (start | abort)   reload <= 1'b0;
      else if (byte_done)  reload <= 1'b1;
      else if (reload_now) reload <= 1'b0;

      if (byte_done) rx_hold <= shifted;
    end
  end

  // A byte handed to the shifter frees the holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_hold   <= '0;
      tx_primed <= 1'b0;
    end else if (tx_wr & ~tx_primed) begin
      tx_hold   <= wdata_q[DATABITS-1:0];
      tx_primed <= 1'b1;
    end else if (load_tx) begin
      tx_primed <= 1'b0;
    end
  end

  assign MISO_oe = ~ss_s;
  assign MISO    = shift_reg[DATABITS-1] & MISO_oe;

  // ---------------- flags, status, irq ----------------
  logic       rrdy, roe, toe, tur, eop, e_flag, trdy, tmt, active;
  logic [7:0] ctrl;
  logic [15:0] status;

  assign active = (state == ACTIVE);
  assign trdy   = ~tx_primed;
  assign tmt    = ~tx_primed & ~active;
  assign e_flag = toe | roe | tur;
  assign status = {6'b0, eop, e_flag, rrdy, trdy, tmt, toe, roe, tur, 2'b00};

  // Set terms are ORed after the clear so a same-cycle set wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rrdy <= 1'b0;
      roe  <= 1'b0;
      toe  <= 1'b0;
      tur  <= 1'b0;
      ctrl <= '0;
      irq  <= 1'b0;
    end else begin
      rrdy <= byte_done | (rrdy & ~rx_rd);
      roe  <= (byte_done & rrdy) | (roe & ~st_wr);
      toe  <= (tx_wr & tx_primed) | (toe & ~st_wr);
      tur  <= (load_tx & ~tx_primed) | (tur & ~st_wr);
      if (ctl_wr) ctrl <= wdata_q[9:2];
      irq  <= |(status[9:2] & ctrl);
    end
  end

`ifdef SPI_SLAVE_EOP_EN
  logic [15:0] eopval;
  logic        eop_set;

  assign eop_set = (byte_done && (shifted == eopval[DATABITS-1:0])) ||
                   (tx_wr && (wdata_q[DATABITS-1:0] == eopval[DATABITS-1:0]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eopval <= '0;
      eop    <= 1'b0;
    end else begin
      if (wr_stb && acc_addr == 3'd6) eopval <= wdata_q;
      eop <= eop_set | (eop & ~st_wr);
    end
  end
`else
  assign eop = 1'b0;
`endif

  // Read mux is registered straight from the live address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_to_cpu <= '0;
    end else begin
      case (mem_addr)
        3'd0:    data_to_cpu <= {{(16-DATABITS){1'b0}}, rx_hold};
        3'd2:    data_to_cpu <= status;
        3'd3:    data_to_cpu <= {6'b0, ctrl, 2'b00};
`ifdef SPI_SLAVE_EOP_EN
        3'd6:    data_to_cpu <= eopval;
`endif
        default: data_to_cpu <= '0;
      endcase
    end
  end

  assign dataavailable = rrdy;
  assign readyfordata  = trdy;
  assign endofpacket   = eop;

endmodule
